cia_tod_tick_sched: RTL and testbench
=====================================

CIA_TOD_TICK_SCHED -- requirements
Module: cia_tod_tick_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset, honoured on any clk edge regardless of clk7_en.
REQ-003 SHALL have ports: clk7_en  in  1  7 MHz enable; all non-reset state advances only when high.
REQ-004 SHALL have ports: tick_in  in  1  asynchronous TOD source (vsync, hsync or power-line 50/60 Hz).
REQ-005 SHALL have ports: div_sel  in  2  prescale: 00 = /1, 01 = /5, 10 = /6, 11 = /1.
REQ-006 SHALL have ports: hold  in  1  high while the CPU writes TOD; defers new issues.
REQ-007 SHALL have ports: clr_ovf  in  1  clears the sticky overflow flag.
REQ-008 SHALL have ports: count_out  out  1  registered TOD count pulse, one clk7_en cycle wide.
REQ-009 SHALL have ports: pending  out  3  number of queued, not-yet-issued ticks.
REQ-010 SHALL have ports: ovf  out  1  sticky flag: a tick was dropped.

Function
REQ-011 SHALL synchronise tick_in through two flops (s0, s1) plus edge flop s2; edge = s1 & ~s2, evaluated on clk7_en cycles.
REQ-012 SHALL count edges in a 3-bit prescaler; event fires on the edge that makes the count reach div-1, prescaler wraps to 0 at that edge; /1 fires on every edge.
REQ-013 SHALL clear the prescaler, without firing, on any clk7_en cycle where div_sel differs from its registered copy.
REQ-014 SHALL update pending per clk7_en cycle as pending + event - issue; simultaneous event and issue leave pending unchanged.
REQ-015 SHALL, on event with pending = 7 and no issue that cycle, drop the event, hold pending at 7 and set ovf.
REQ-016 SHALL clear ovf on clr_ovf; an overflow set and clr_ovf in the same cycle leaves ovf = 1.
REQ-017 SHALL implement FSM IDLE -> ISSUE -> GAP -> IDLE, advancing only on clk7_en.
REQ-018 SHALL go IDLE -> ISSUE when pending != 0 and hold = 0; otherwise stay in IDLE.
REQ-019 SHALL go unconditionally ISSUE -> GAP, and GAP -> IDLE; hold has no effect in ISSUE or GAP.
REQ-020 SHALL drive count_out = 1 only while the state is ISSUE, as a registered output.
REQ-021 SHALL use ISSUE as the issue term for pending; minimum spacing between count_out pulses is 3 clk7_en cycles, which guarantees the TOD carry phase.
REQ-022 SHALL hold all state, including count_out level, while clk7_en = 0.
REQ-023 SHALL give latency: tick_in high before enabled edge E0, /1, pending = 0, hold = 0 -> pending = 1 after E2, count_out high after E3 and low after E4.
REQ-024 SHALL, when hold is released with pending = N, issue N pulses at 3-cycle spacing with no pulse lost.

Reset
REQ-025 SHALL on reset set state = IDLE, count_out = 0, pending = 0, ovf = 0, prescaler = 0, s0 = s1 = s2 = 0, and registered div_sel = the current div_sel.
REQ-026 SHALL abort any in-flight ISSUE or GAP on reset mid-operation and discard all queued ticks.
REQ-027 SHALL produce no count_out pulse on the first enabled cycle after reset, even with tick_in = 1; only a subsequent rising edge is counted.

Verification
REQ-028 SHALL cover: div_sel = 00, single tick_in rise -> count_out high exactly one clk7_en cycle after E3; pending returns to 0.
REQ-029 SHALL cover: div_sel = 10, 12 tick_in rises -> exactly 2 count_out pulses, on the 6th and 12th edges; div_sel = 01, 10 rises -> 2 pulses.
REQ-030 SHALL cover: hold = 1, 5 ticks -> pending = 5, no count_out; release hold -> 5 pulses spaced 3 enabled cycles; pending = 0.
REQ-031 SHALL cover: hold = 1, 9 ticks -> pending = 7, ovf = 1; clr_ovf -> ovf = 0 while pending stays 7.
REQ-032 SHALL cover: clk7_en duty 1 of 4 -> identical pulse count; count_out stays high for 4 clk cycles.
REQ-033 SHALL cover: reset asserted during ISSUE with pending = 3 -> next cycle count_out = 0, pending = 0, state IDLE.

Source files
------------

// File: rtl/cia_tod_tick_sched.sv
// cia_tod_tick_sched: schedules TOD count pulses from an asynchronous tick source.
//   tick_in is synchronised, edge-detected and prescaled (/1, /5 or /6). Each
//   prescaled event is queued, and an IDLE->ISSUE->GAP FSM drains the queue as
//   one-cycle count pulses. The pulses are at least 3 enabled cycles apart, so
//   the TOD carry chain always has time to settle between them.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, honoured regardless of clk7_en
//   clk7_en    7 MHz enable; all other state only advances while it is high
//   tick_in    asynchronous TOD source
//   div_sel    prescale select: 00=/1, 01=/5, 10=/6, 11=/1
//   hold       defers new issues while the CPU writes TOD
//   clr_ovf    clears the sticky overflow flag
//   count_out  registered TOD count pulse, one enabled cycle wide
//   pending    number of queued ticks that are not yet issued
//   ovf        sticky flag: a tick was dropped because the queue was full
module cia_tod_tick_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       tick_in,
  input  logic [1:0] div_sel,
  input  logic       hold,
  input  logic       clr_ovf,
  output logic       count_out,
  output logic [2:0] pending,
  output logic       ovf
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e     state_q, state_d;
  logic       s0_q, s1_q, s2_q;
  logic [1:0] div_q;
  logic [2:0] presc_q, presc_d;
  logic [2:0] pending_q, pending_d;
  logic       ovf_q, ovf_d;
  logic       count_q, count_d;

  logic       edge_det;
  logic       div_chg;
  logic [2:0] div_m1;
  logic       fire;
  logic       issue;
  logic       drop;

  assign edge_det = s1_q & ~s2_q;
  assign div_chg  = (div_sel != div_q);
  assign issue    = (state_q == StIssue);

  // Terminal prescaler count for the registered divider setting.
  always_comb begin
    div_m1 = 3'd0;
    unique case (div_q)
      2'b01:   div_m1 = 3'd4;
      2'b10:   div_m1 = 3'd5;
      default: div_m1 = 3'd0;
    endcase
  end

  // Prescaler: a divider change restarts the count and swallows that cycle's edge.
  always_comb begin
    presc_d = presc_q;
    fire    = 1'b0;
    if (div_chg) begin
      presc_d = 3'd0;
    end else if (edge_det) begin
      if (presc_q == div_m1) begin
        fire    = 1'b1;
        presc_d = 3'd0;
      end else begin
        presc_d = presc_q + 3'd1;
      end
    end
  end

  // Queue depth and overflow; an event that meets a full queue with no issue is lost.
  always_comb begin
    pending_d = pending_q;
    drop      = 1'b0;
    if (fire && !issue) begin
      if (pending_q == 3'd7) begin
        drop = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (!fire && issue) begin
      pending_d = pending_q - 3'd1;
    end
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    // Set wins over clear in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Issue FSM; count_out is the registered image of the ISSUE state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pending_q != 3'd0 && !hold) state_d = StIssue;
      StIssue: state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    count_d = (state_d == StIssue);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      div_q     <= div_sel;
      presc_q   <= 3'd0;
      pending_q <= 3'd0;
      ovf_q     <= 1'b0;
      count_q   <= 1'b0;
    end else if (clk7_en) begin
      state_q   <= state_d;
      s0_q      <= tick_in;
      s1_q      <= s0_q;
      s2_q      <= s1_q;
      div_q     <= div_sel;
      presc_q   <= presc_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  assign count_out = count_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cia_tod_tick_sched.sv
// Scoreboard bench for cia_tod_tick_sched. Stimulus pushes the expected enabled
// cycle and width of each count_out pulse; a monitor checks every pulse it sees.
module tb_cia_tod_tick_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk7_en = 1'b1;
  logic       tick_in = 1'b0;
  logic [1:0] div_sel = 2'b00;
  logic       hold = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       count_out;
  logic [2:0] pending;
  logic       ovf;

  cia_tod_tick_sched dut (
    .clk       (clk),
    .reset     (reset),
    .clk7_en   (clk7_en),
    .tick_in   (tick_in),
    .div_sel   (div_sel),
    .hold      (hold),
    .clr_ovf   (clr_ovf),
    .count_out (count_out),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int width;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   en_cyc = 0;
  bit   duty4 = 1'b0;
  int   ph = 0;

  // Count enabled clock edges; pulse expectations are expressed in these units.
  always @(posedge clk) if (clk7_en) en_cyc <= en_cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      clk7_en = duty4 ? (ph == 0) : 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on each count_out rise pop and compare the cycle, on fall the width.
  logic mon_prev = 1'b0;
  int   mon_w = 0;
  int   mon_wexp = -1;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (count_out === 1'b1 && !mon_prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: count_out rose at enabled cycle %0d, none queued",
                   en_cyc);
          mon_wexp = -1;
        end else begin
          mon_e = sb.pop_front();
          check("pulse_cycle", en_cyc, mon_e.cyc);
          mon_wexp = mon_e.width;
        end
        mon_w = 1;
      end else if (count_out === 1'b1) begin
        mon_w++;
      end else if (mon_prev && mon_wexp >= 0) begin
        check("pulse_width", mon_w, mon_wexp);
      end
      mon_prev = (count_out === 1'b1);
    end
  end

  task automatic wait_en(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (clk7_en !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic push(input int c, input int w);
    exp_t e;
    e.cyc = c;
    e.width = w;
    sb.push_back(e);
  endtask

  // One tick_in rise: high for 2 enabled cycles, low for 2. A counted event
  // shows up as count_out after the 4th enabled edge from the rise.
  task automatic rise(input bit exp_pulse, input int w);
    @(negedge clk);
    if (exp_pulse) push(en_cyc + 4, w);
    tick_in = 1'b1;
    wait_en(2);
    @(negedge clk);
    tick_in = 1'b0;
    wait_en(2);
  endtask

  task automatic do_reset(input logic [1:0] d);
    @(negedge clk);
    reset = 1'b1;
    div_sel = d;
    hold = 1'b0;
    clr_ovf = 1'b0;
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    wait_en(8);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  int c;

  initial begin
    // Reset state
    do_reset(2'b00);
    @(negedge clk);
    check("rst_count_out", int'(count_out), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_ovf", int'(ovf), 0);

    // /1 single rise: pulse after E3, queue empties
    rise(1'b1, 1);
    drain("div1_missing");
    check("div1_pending", int'(pending), 0);

    // /6: pulses on 6th and 12th rise
    do_reset(2'b10);
    for (int i = 0; i < 12; i++) rise(i % 6 == 5, 1);
    drain("div6_missing");

    // /5: pulses on 5th and 10th rise
    do_reset(2'b01);
    for (int i = 0; i < 10; i++) rise(i % 5 == 4, 1);
    drain("div5_missing");

    // hold with 5 ticks, then release: 5 pulses 3 enabled cycles apart
    do_reset(2'b00);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) rise(1'b0, 1);
    @(negedge clk);
    check("hold_pending5", int'(pending), 5);
    c = en_cyc;
    for (int k = 0; k < 5; k++) push(c + 1 + 3 * k, 1);
    hold = 1'b0;
    wait_en(16);
    @(negedge clk);
    check("hold_pending0", int'(pending), 0);
    drain("hold_missing");

    // overflow: 7 ticks fill the queue cleanly, more set ovf
    do_reset(2'b00);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) rise(1'b0, 1);
    @(negedge clk);
    check("full_pending", int'(pending), 7);
    check("full_no_ovf", int'(ovf), 0);
    for (int i = 0; i < 2; i++) rise(1'b0, 1);
    @(negedge clk);
    check("ovf_pending", int'(pending), 7);
    check("ovf_set", int'(ovf), 1);
    clr_ovf = 1'b1;
    wait_en(1);
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", int'(ovf), 0);
    check("ovf_pending_kept", int'(pending), 7);

    // clk7_en duty 1 of 4: same pulses, each 4 clk cycles wide
    do_reset(2'b00);
    duty4 = 1'b1;
    rise(1'b1, 4);
    rise(1'b1, 4);
    drain("duty_missing");
    check("duty_pending", int'(pending), 0);
    duty4 = 1'b0;

    // reset during ISSUE with pending = 3
    do_reset(2'b00);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) rise(1'b0, 1);
    @(negedge clk);
    check("pre_issue_pending", int'(pending), 3);
    push(en_cyc + 1, 1);
    hold = 1'b0;
    wait_en(1);
    @(negedge clk);
    check("issue_count_out", int'(count_out), 1);
    check("issue_pending", int'(pending), 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_count_out", int'(count_out), 0);
    check("abort_pending", int'(pending), 0);
    @(negedge clk);
    reset = 1'b0;
    drain("abort_extra");
    check("abort_pending_after", int'(pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
